fifo_rd_fwft: RTL

Read-domain output stage for the type-1 asynchronous FIFO. It sits between the read-pointer/empty generator and the FIFO memory read port on one side and a downstream consumer on the other. It fetches words ahead of demand and presents them first-word-fall-through on a valid/ready interface, sustaining one word per rd_clk cycle. Optionally it reports the total occupancy visible from the read domain.

---
 rtl/fifo_rd_fwft.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_rd_fwft.sv
// Read-domain FWFT output stage for the type-1 async FIFO: prefetches into a 2-entry buffer.
// Read-domain occupancy report is built only when FIFO_RD_LEVEL_EN is defined.
module fifo_rd_fwft #(
    parameter int unsigned AddressWidth = 16,
    parameter int unsigned DataWidth    = 32
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic                    rd_empty,
    output logic                    rd_req,
    input  logic [DataWidth-1:0]    rd_mem_data,
    input  logic [AddressWidth:0]   rd_ptr,
    input  logic [AddressWidth:0]   rd_q_wptr,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DataWidth-1:0]    m_data,
    output logic [AddressWidth+1:0] rd_level
);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t           r_state;
    buf_state_t           w_state_nxt;
    logic                 r_inflight;
    logic                 r_m_valid;
    logic [DataWidth-1:0] r_entry0;
    logic [DataWidth-1:0] r_entry1;
    logic [DataWidth-1:0] w_entry0_nxt;
    logic [DataWidth-1:0] w_entry1_nxt;
    logic                 w_pop;
    logic                 w_room;
    logic                 w_rd_req;

    // Room exists while buffered plus in-flight words stay below two.
    assign w_pop    = r_m_valid & m_ready;
    assign w_room   = (r_state == BUF_EMPTY) | ((r_state == BUF_ONE) & ~r_inflight);
    assign w_rd_req = ~rd_empty & (w_room | w_pop);

    assign rd_req  = w_rd_req;
    assign m_valid = r_m_valid;
    assign m_data  = r_entry0;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_state    <= BUF_EMPTY;
            r_inflight <= 1'b0;
            r_m_valid  <= 1'b0;
            r_entry0   <= '0;
            r_entry1   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd_req;
            r_m_valid  <= (w_state_nxt != BUF_EMPTY);
            r_entry0   <= w_entry0_nxt;
            r_entry1   <= w_entry1_nxt;
        end
    end

    // Buffer occupancy and entry update: capture of the in-flight word and/or pop of the head.
    always_comb begin
        w_state_nxt  = r_state;
        w_entry0_nxt = r_entry0;
        w_entry1_nxt = r_entry1;
        case (r_state)
            BUF_EMPTY: begin
                if (r_inflight) begin
                    w_entry0_nxt = rd_mem_data;
                    w_state_nxt  = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (r_inflight && w_pop) begin
                    w_entry0_nxt = rd_mem_data;
                end else if (r_inflight) begin
                    w_entry1_nxt = rd_mem_data;
                    w_state_nxt  = BUF_TWO;
                end else if (w_pop) begin
                    w_state_nxt  = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (w_pop) begin
                    w_entry0_nxt = r_entry1;
                    if (r_inflight) begin
                        w_entry1_nxt = rd_mem_data;
                    end else begin
                        w_state_nxt  = BUF_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = BUF_EMPTY;
            end
        endcase
    end

`ifdef FIFO_RD_LEVEL_EN
    localparam int unsigned PtrWidth   = AddressWidth + 1;
    localparam int unsigned LevelWidth = AddressWidth + 2;

    function automatic logic [PtrWidth-1:0] gray2bin(input logic [PtrWidth-1:0] g);
        logic [PtrWidth-1:0] b;
        b = '0;
        for (int i = 0; i < int'(PtrWidth); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PtrWidth-1:0]   w_wbin;
    logic [PtrWidth-1:0]   w_rbin;
    logic [PtrWidth-1:0]   w_mem_words;
    logic [1:0]            w_buf_cnt;
    logic [LevelWidth-1:0] w_level_nxt;
    logic [LevelWidth-1:0] r_level;

    // Memory words plus words already pulled into this stage; modulo pointer arithmetic handles wrap.
    assign w_wbin      = gray2bin(rd_q_wptr);
    assign w_rbin      = gray2bin(rd_ptr);
    assign w_mem_words = w_wbin - w_rbin;
    assign w_buf_cnt   = r_state;
    assign w_level_nxt = LevelWidth'(w_mem_words) + LevelWidth'(w_buf_cnt)
                       + LevelWidth'(r_inflight);

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_level <= '0;
        end else begin
            r_level <= w_level_nxt;
        end
    end

    assign rd_level = r_level;
`else
    logic w_unused_ptrs;

    assign w_unused_ptrs = ^{rd_ptr, rd_q_wptr};
    assign rd_level      = '0;
`endif

endmodule
